dm_resp: RTL and testbench
==========================

Name: dm_resp

Overview:
- Data-memory responder for the MEM stage. It services the memory access that the EX/MEM pipeline register issues each cycle: address from ALU output, store data, PC and store strobe.
- Word-organised RAM with byte, halfword and word stores and loads. Loads are sign- or zero-extended.
- Feeds load data to the MEM/WB register.

Parameters:
- ADDR_WIDTH, 10, word-index width; depth = 2^ADDR_WIDTH words (default 1024 words = 4 KiB).
- INIT_VALUE, 32'h0000_0000, value every word takes on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears memory and the error flag.
- MemWrite  input  1  store strobe, qualified every cycle.
- Size  input  2  access size: 0 = word, 1 = halfword, 2 = byte, 3 = reserved (treated as word).
- SignExt  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- AO  input  32  byte address (ALU output).
- WD  input  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- PC  input  32  PC of the accessing instruction; used only for the write log.
- RD  output  32  load data, extended to 32 bits.
- Misalign  output  1  combinational flag for the current access being misaligned.
- ErrSticky  output  1  registered flag; set by any misaligned store.

Behaviour:
- Reset:
  - Asynchronous: while reset = 1, every word equals INIT_VALUE and ErrSticky = 0.
  - No write takes effect on a clock edge that occurs while reset is high.
  - Reset asserted mid-operation aborts nothing pending, because stores complete in one edge.
- Indexing:
  - Word index = AO[ADDR_WIDTH+1:2].
  - Bits above the index are ignored, so addresses wrap modulo the depth (AO = 32'h1000 aliases 32'h0 at the default depth).
  - Byte lane = AO[1:0].
- Misalignment (combinational):
  - Misalign = 1 when (Size = 1 and AO[0] = 1) or (Size in {0,3} and AO[1:0] != 0).
  - Misalign is computed regardless of MemWrite.
- Store (latency 1):
  - At posedge clk with MemWrite = 1 and Misalign = 0, only the addressed lanes are updated.
  - Byte: lane AO[1:0] <= WD[7:0].
  - Halfword: bits [15:0] if AO[1] = 0, else bits [31:16], <= WD[15:0].
  - Word: all 32 bits <= WD.
  - All other bits are unchanged.
- Misaligned store:
  - No memory change.
  - ErrSticky <= 1 at that edge and holds until reset.
- Load (combinational, latency 0):
  - Word W = mem[index], then select by Size.
  - Byte: lane AO[1:0] of W, extended per SignExt.
  - Halfword: W[15:0] if AO[1] = 0, else W[31:16], extended per SignExt.
  - Word: W.
  - RD is valid every cycle whether or not a load is in flight. With Size = 0, SignExt is ignored.
  - A misaligned load returns the data selected by the truncated lane bits (AO[0] is ignored for halfword, AO[1:0] for word) and raises Misalign.
- Read-during-write, same word: RD shows the old contents until the edge and the new contents after it. There is no internal bypass.
- With MemWrite = 0, memory never changes.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: on every successful store edge, a simulation display line is printed: "@<PC hex 8>: *<word-aligned address hex 8> <= <full resulting word hex 8>". The address is {AO[31:2],2'b00} and the data is the merged 32-bit word after the partial store. Misaligned stores print nothing.
- Undefined: no display statements; synthesis-clean; functionally identical otherwise.

Test Plan:
- Reset then read: assert reset, release. AO = 32'h0, 32'h3FFC, Size = 0 -> RD = 32'h0; ErrSticky = 0.
- Word store/load: MemWrite = 1, Size = 0, AO = 32'h8, WD = 32'hDEADBEEF, one edge. Then MemWrite = 0 -> RD = 32'hDEADBEEF. With DM_WRITE_LOG_EN and PC = 32'h3010 -> log "@00003010: *00000008 <= deadbeef".
- Byte and halfword merge: after the word store above, store byte WD = 32'h11 at AO = 32'h9. Then halfword WD = 32'h2233 at AO = 32'hA.
  - Word load at 32'h8 -> 32'h223311EF.
  - Byte load at 32'h8, SignExt = 1 -> 32'hFFFFFFEF; SignExt = 0 -> 32'h000000EF.
- Misaligned store: word store WD = 32'h5 at AO = 32'h6 -> Misalign = 1 that cycle. Word at 32'h4 is unchanged (32'h0), ErrSticky = 1 after the edge, and there is no log line.
- Wrap-around: word store WD = 32'hCAFEF00D at AO = 32'h1004 -> word load at AO = 32'h4 returns 32'hCAFEF00D.
- Async reset mid-run: with ErrSticky = 1 and memory populated, pulse reset between clock edges -> RD = 32'h0 and ErrSticky = 0 immediately, without waiting for a clock edge. A store edge while reset = 1 leaves memory unchanged.

Source files
------------

// File: rtl/dm_resp.sv
// Data-memory responder for the MEM stage: word RAM with byte/halfword/word stores and
// sign/zero-extended loads. Define DM_WRITE_LOG_EN to print one log line per completed store.
module dm_resp #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] AO,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        Misalign,
  output logic        ErrSticky
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           word_rd;
  logic [3:0]            be;
  logic [31:0]           wd_rep;
  logic [31:0]           wr_merged;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign idx     = AO[ADDR_WIDTH+1:2];
  assign lane    = AO[1:0];
  assign word_rd = mem_q[idx];

  // PC is consumed only by the optional write log; high address bits alias by design.
  logic unused_ok;
  assign unused_ok = ^{PC, AO[31:ADDR_WIDTH+2]};

  always_comb begin
    Misalign = 1'b0;
    be       = 4'b1111;
    wd_rep   = WD;
    unique case (Size)
      2'd1: begin
        Misalign = AO[0];
        be       = AO[1] ? 4'b1100 : 4'b0011;
        wd_rep   = {WD[15:0], WD[15:0]};
      end
      2'd2: begin
        Misalign = 1'b0;
        be       = 4'b0001 << lane;
        wd_rep   = {4{WD[7:0]}};
      end
      default: begin
        Misalign = |AO[1:0];
        be       = 4'b1111;
        wd_rep   = WD;
      end
    endcase
  end

  // Partial store merges the enabled lanes into the current word contents.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign wr_merged[8*g +: 8] = be[g] ? wd_rep[8*g +: 8] : word_rd[8*g +: 8];
  end

  assign byte_sel = word_rd[8*lane +: 8];
  assign half_sel = AO[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    RD = word_rd;
    unique case (Size)
      2'd1:    RD = {{16{SignExt & half_sel[15]}}, half_sel};
      2'd2:    RD = {{24{SignExt & byte_sel[7]}}, byte_sel};
      default: RD = word_rd;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VALUE;
      err_q <= 1'b0;
    end else if (MemWrite) begin
      if (Misalign) err_q <= 1'b1;
      else          mem_q[idx] <= wr_merged;
    end
  end

  assign ErrSticky = err_q;

`ifdef DM_WRITE_LOG_EN
  always @(posedge clk) begin
    if (!reset && MemWrite && !Misalign)
      $display("@%08h: *%08h <= %08h", PC, {AO[31:2], 2'b00}, wr_merged);
  end
`else
`endif

endmodule

// File: tb/tb_dm_resp.sv
// Randomized scoreboard bench for dm_resp against a byte-addressed reference memory.
module tb_dm_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size = 2'd0;
  logic        SignExt = 1'b0;
  logic [31:0] AO = '0;
  logic [31:0] WD = '0;
  logic [31:0] PC = '0;
  logic [31:0] RD;
  logic        Misalign;
  logic        ErrSticky;

  dm_resp dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Size(Size), .SignExt(SignExt),
    .AO(AO), .WD(WD), .PC(PC), .RD(RD), .Misalign(Misalign), .ErrSticky(ErrSticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        err;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  int   ncyc = 0;

  // Reference: 4 KiB of bytes, little-endian lanes, addresses wrap at 4096.
  logic [7:0] mem_b [4096];
  logic       m_err;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] ao, input logic [1:0] sz,
                                         input logic se);
    int n = nbytes(sz);
    int a = int'(ao[11:0]) & ~(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[a + i];
    if (se && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic m_mis(input logic [31:0] ao, input logic [1:0] sz);
    return (int'(ao[1:0]) % nbytes(sz)) != 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
    m_err = 1'b0;
  endtask

  // One cycle: called just after a rising edge; pushes the expectation, waits for the next edge.
  task automatic cyc(input logic rst_v, input logic we, input logic [1:0] sz, input logic se,
                     input logic [31:0] ao, input logic [31:0] wd);
    exp_t e;
    reset = rst_v; MemWrite = we; Size = sz; SignExt = se; AO = ao; WD = wd;
    PC = 32'h3000 + 32'(ncyc * 4);
    if (rst_v) m_clear();
    e.rd = m_load(ao, sz, se); e.mis = m_mis(ao, sz); e.err = m_err; e.id = ncyc;
    q.push_back(e);
    @(posedge clk); #1;
    if (!rst_v && we) begin
      if (m_mis(ao, sz)) m_err = 1'b1;
      else begin
        int n = nbytes(sz);
        int a = int'(ao[11:0]);
        for (int i = 0; i < n; i++) mem_b[a + i] = wd[8*i +: 8];
      end
    end
    ncyc++;
  endtask

  // Monitor: compares whatever the DUT presents at the falling edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (RD !== e.rd) begin
          failures++;
          $display("FAIL rd cyc=%0d got=%08h exp=%08h", e.id, RD, e.rd);
        end
        checks++;
        if (Misalign !== e.mis) begin
          failures++;
          $display("FAIL misalign cyc=%0d got=%b exp=%b", e.id, Misalign, e.mis);
        end
        checks++;
        if (ErrSticky !== e.err) begin
          failures++;
          $display("FAIL errsticky cyc=%0d got=%b exp=%b", e.id, ErrSticky, e.err);
        end
      end
    end
  end

  initial begin
    m_clear();
    reset = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, 2'd0, 0, 32'h0, 32'h0);
    // Reset, then read back
    cyc(0, 0, 2'd0, 0, 32'h0, 32'h0);
    cyc(0, 0, 2'd0, 0, 32'h3FFC, 32'h0);
    // Word store and load
    cyc(0, 1, 2'd0, 0, 32'h8, 32'hDEADBEEF);
    cyc(0, 0, 2'd0, 0, 32'h8, 32'h0);
    // Byte and halfword merge
    cyc(0, 1, 2'd2, 0, 32'h9, 32'h11);
    cyc(0, 1, 2'd1, 0, 32'hA, 32'h2233);
    cyc(0, 0, 2'd0, 0, 32'h8, 32'h0);
    cyc(0, 0, 2'd2, 1, 32'h8, 32'h0);
    cyc(0, 0, 2'd2, 0, 32'h8, 32'h0);
    cyc(0, 0, 2'd1, 1, 32'hA, 32'h0);
    // Misaligned store
    cyc(0, 1, 2'd0, 0, 32'h6, 32'h5);
    cyc(0, 0, 2'd0, 0, 32'h4, 32'h0);
    // Wrap-around aliasing
    cyc(0, 1, 2'd0, 0, 32'h1004, 32'hCAFEF00D);
    cyc(0, 0, 2'd0, 0, 32'h4, 32'h0);
    // Misaligned loads and reserved size
    cyc(0, 0, 2'd1, 1, 32'hB, 32'h0);
    cyc(0, 0, 2'd3, 0, 32'h7, 32'h0);
    // Async reset between edges, including a store attempted while reset is high
    cyc(1, 1, 2'd0, 0, 32'h8, 32'h12345678);
    cyc(0, 0, 2'd0, 0, 32'h8, 32'h0);
    cyc(0, 0, 2'd0, 0, 32'h1004, 32'h0);
    // Randomized traffic concentrated on a small window, with occasional aliasing and resets
    for (int k = 0; k < 600; k++) begin
      logic [31:0] a;
      logic        r;
      a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0, 12'($urandom_range(0, 63))};
      r = ($urandom_range(0, 79) == 0);
      cyc(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom);
    end
    done = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
